// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes, field positions and reset constants
package cp0_pkg;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,  EXC_MOD = 5'd1,  EXC_TLBL = 5'd2,  EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,  EXC_ADES = 5'd5, EXC_IBE = 5'd6,   EXC_DBE = 5'd7,
    EXC_SYS  = 5'd8,  EXC_BP = 5'd9,   EXC_RI = 5'd10,   EXC_CPU = 5'd11,
    EXC_OV   = 5'd12, EXC_TR = 5'd13
  } exc_code_e;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;
  localparam int CA_IV  = 23;
  localparam int CA_WP  = 22;
  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RST = 32'h0000_8000;
  localparam logic [31:0] PRID_RST   = 32'h004C_0102;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: one Compare register with a sticky match flag cleared by its own write
module cp0_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_count,
  input  logic        i_we,
  input  logic [31:0] i_w_data,
  output logic [31:0] o_compare,
  output logic        o_flag
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_compare <= '0;
      o_flag    <= 1'b0;
    end else if (i_we) begin
      o_compare <= i_w_data;
      o_flag    <= 1'b0;
    end else if (o_compare != '0 && i_count == o_compare)
      o_flag <= 1'b1;
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 registers, prescaled Count, timer channels, exception/ERET commit
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int N_INT   = 6,
  parameter int N_TIMER = 1,
  parameter int CNT_DIV = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [4:0]         i_r_addr,
  input  logic [2:0]         i_r_sel,
  output logic [31:0]        o_r_data,
  input  logic               i_w_en,
  input  logic [4:0]         i_w_addr,
  input  logic [2:0]         i_w_sel,
  input  logic [31:0]        i_w_data,
  input  logic [N_INT-1:0]   i_interrupt,
  input  logic               i_exc_valid,
  input  logic [4:0]         i_exc_code,
  input  logic [31:0]        i_exc_pc,
  input  logic               i_exc_bd,
  input  logic               i_eret,
  output logic [31:0]        o_status,
  output logic [31:0]        o_cause,
  output logic [31:0]        o_epc,
  output logic [N_TIMER-1:0] o_timer_int,
  output logic               o_int_req
);
  logic [31:0] count, presc, status, status_d, epc;
  logic [31:0] cmp [8];
  logic [5:0]  ip_hw, ip_d;
  logic [4:0]  exc;
  logic [1:0]  ip_sw;
  logic        bd, iv, wp, ti, tick, epc_upd;
  logic        w_count, w_status, w_cause, w_epc;
  assign w_count  = i_w_en && i_w_addr == REG_COUNT;
  assign w_status = i_w_en && i_w_addr == REG_STATUS;
  assign w_cause  = i_w_en && i_w_addr == REG_CAUSE;
  assign w_epc    = i_w_en && i_w_addr == REG_EPC;
  assign tick     = presc == 32'(CNT_DIV - 1);
  assign epc_upd  = i_exc_valid && !status[ST_EXL];
  assign ti       = |o_timer_int;
  // EXL is the only Status bit with commit priority: exception sets, ERET clears, else MTC0/hold
  always_comb begin
    ip_d               = 6'(i_interrupt);
    ip_d[5]            = ip_d[5] | ti;
    status_d           = w_status ? i_w_data : status;
    status_d[ST_EXL]   = i_exc_valid | (~i_eret & (w_status ? i_w_data[ST_EXL] : status[ST_EXL]));
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      count  <= '0;
      presc  <= '0;
      status <= STATUS_RST;
      epc    <= '0;
      bd     <= 1'b0;
      exc    <= '0;
      ip_sw  <= '0;
      iv     <= 1'b0;
      wp     <= 1'b0;
      ip_hw  <= '0;
    end else begin
      presc  <= (w_count || tick) ? '0 : presc + 32'd1;
      count  <= w_count ? i_w_data : count + {31'b0, tick};
      status <= status_d;
      ip_hw  <= ip_d;
      if (epc_upd) begin
        epc <= i_exc_bd ? i_exc_pc - 32'd4 : i_exc_pc;
        bd  <= i_exc_bd;
      end else if (w_epc)
        epc <= i_w_data;
      if (i_exc_valid) exc <= i_exc_code;
      if (w_cause) {iv, wp, ip_sw} <= {i_w_data[CA_IV], i_w_data[CA_WP], i_w_data[9:8]};
    end
  for (genvar k = 0; k < 8; k++) begin : g_tmr
    if (k < N_TIMER) begin : g_on
      cp0_timer u_tmr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_count   (count),
        .i_we      (i_w_en && i_w_addr == REG_COMPARE && i_w_sel == 3'(k)),
        .i_w_data  (i_w_data),
        .o_compare (cmp[k]),
        .o_flag    (o_timer_int[k])
      );
    end else begin : g_off
      assign cmp[k] = '0;
    end
  end
  assign o_status  = status;
  assign o_cause   = {bd, ti, 6'b0, iv, wp, 6'b0, ip_hw, ip_sw, 1'b0, exc, 2'b0};
  assign o_epc     = epc;
  assign o_int_req = status[ST_IE] & ~status[ST_EXL] & |(o_cause[15:8] & status[15:8]);
  assign o_r_data  = i_r_addr == REG_COUNT   ? count :
                     i_r_addr == REG_COMPARE ? cmp[i_r_sel] :
                     i_r_addr == REG_STATUS  ? status :
                     i_r_addr == REG_CAUSE   ? o_cause :
                     i_r_addr == REG_EPC     ? epc :
                     i_r_addr == REG_PRID    ? PRID_RST :
                     i_r_addr == REG_CONFIG  ? CONFIG_RST : '0;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: scoreboard bench for cp0_ctrl with N_TIMER=2, CNT_DIV=4
module tb_cp0_ctrl;
  import cp0_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [4:0]  r_addr = '0, w_addr = '0, exc_code = '0;
  logic [2:0]  r_sel = '0, w_sel = '0;
  logic [31:0] r_data, w_data = '0, exc_pc = '0, status, cause, epc;
  logic        w_en = 1'b0, exc_valid = 1'b0, exc_bd = 1'b0, eret = 1'b0, int_req;
  logic [5:0]  irq = '0;
  logic [1:0]  timer_int;
  always #50 clk = ~clk;
  cp0_ctrl #(.N_INT(6), .N_TIMER(2), .CNT_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_r_addr(r_addr), .i_r_sel(r_sel), .o_r_data(r_data),
    .i_w_en(w_en), .i_w_addr(w_addr), .i_w_sel(w_sel), .i_w_data(w_data),
    .i_interrupt(irq), .i_exc_valid(exc_valid), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_bd(exc_bd), .i_eret(eret), .o_status(status), .o_cause(cause), .o_epc(epc),
    .o_timer_int(timer_int), .o_int_req(int_req)
  );
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got %h, want no pending entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pop_rd(input logic [4:0] a, input logic [2:0] s);
    r_addr = a;
    r_sel  = s;
    #1 pop(r_data);
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_sel = s; w_data = d;
    tick();
    w_en = 1'b0;
  endtask
  task automatic raise(input logic [4:0] c, input logic [31:0] pc, input logic bd);
    exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_bd = bd;
    tick();
    exc_valid = 1'b0;
  endtask
  initial begin
    tick(2);
    rst_n = 1'b1;
    push("rst_status", STATUS_RST); push("rst_cause", 0); push("rst_epc", 0);
    push("rst_timer", 0); push("rst_intreq", 0);
    push("rst_count", 0); push("rst_config", 32'h0000_8000); push("rst_prid", 32'h004C_0102);
    pop(status); pop(cause); pop(epc); pop({30'b0, timer_int}); pop({31'b0, int_req});
    pop_rd(REG_COUNT, 0); pop_rd(REG_CONFIG, 0); pop_rd(REG_PRID, 0);
    push("unmapped_rd", 0); pop_rd(5'd20, 0);
    tick(40);
    push("count_40clk", 10); pop_rd(REG_COUNT, 0);
    // timer channel 1: Compare=20, Count=15
    mtc0(REG_COMPARE, 1, 20);
    mtc0(REG_COUNT, 0, 15);
    tick(20);
    push("cnt_at_match", 20); push("flag_before", 0);
    pop_rd(REG_COUNT, 0); pop({30'b0, timer_int});
    tick();
    push("flag_set", 2); push("cause_ti", 1);
    pop({30'b0, timer_int}); pop({31'b0, cause[CA_TI]});
    tick();
    push("cause_ip7", 1); pop({31'b0, cause[15]});
    tick(10);
    push("flag_sticky", 2); push("cmp1_rd", 20);
    pop({30'b0, timer_int}); pop_rd(REG_COMPARE, 1);
    mtc0(REG_COMPARE, 3, 32'h55);
    push("cmp3_rd", 0); push("cmp2_rd", 0);
    pop_rd(REG_COMPARE, 3); pop_rd(REG_COMPARE, 2);
    mtc0(REG_COMPARE, 1, 20);
    push("flag_clr", 0); pop({30'b0, timer_int});
    // exception commit
    raise(EXC_OV, 32'h100, 1'b1);
    push("exc1_epc", 32'hFC); push("exc1_bd", 1); push("exc1_code", 32'(EXC_OV)); push("exc1_status", 32'h1000_0002);
    pop(epc); pop({31'b0, cause[CA_BD]}); pop({27'b0, cause[6:2]}); pop(status);
    raise(EXC_TR, 32'h200, 1'b0);
    push("exc2_epc", 32'hFC); push("exc2_bd", 1); push("exc2_code", 32'(EXC_TR));
    pop(epc); pop({31'b0, cause[CA_BD]}); pop({27'b0, cause[6:2]});
    // interrupt gating and ERET
    mtc0(REG_STATUS, 0, 32'h0000_0401);
    push("int_idle", 0); pop({31'b0, int_req});
    irq = 6'b000001;
    #1 push("int_lag", 0); pop({31'b0, int_req});
    tick();
    push("int_req", 1); pop({31'b0, int_req});
    mtc0(REG_STATUS, 0, 32'h0000_0403);
    push("int_exl", 0); pop({31'b0, int_req});
    eret = 1'b1; tick(); eret = 1'b0;
    push("eret_status", 32'h401); push("eret_int", 1);
    pop(status); pop({31'b0, int_req});
    eret = 1'b1; mtc0(REG_STATUS, 0, 32'h0000_0403); eret = 1'b0;
    push("eret_vs_mtc0", 32'h401); pop(status);
    // collisions
    exc_valid = 1'b1; exc_code = EXC_SYS; exc_pc = 32'h300; exc_bd = 1'b0;
    mtc0(REG_STATUS, 0, 0);
    exc_valid = 1'b0;
    push("col_status", 32'h2); push("col_epc", 32'h300); push("col_bd", 0);
    pop(status); pop(epc); pop({31'b0, cause[CA_BD]});
    mtc0(REG_STATUS, 0, 0);
    exc_valid = 1'b1; exc_pc = 32'h400;
    mtc0(REG_EPC, 0, 32'hDEAD);
    exc_valid = 1'b0;
    push("col_epc_wr", 32'h400); pop(epc);
    mtc0(REG_COUNT, 0, 100);
    tick(3);
    push("cnt_pre_tick", 100); pop_rd(REG_COUNT, 0);
    mtc0(REG_COUNT, 0, 500);
    push("cnt_wr_tick", 500); pop_rd(REG_COUNT, 0);
    tick(3);
    push("cnt_hold", 500); pop_rd(REG_COUNT, 0);
    tick();
    push("cnt_inc", 501); pop_rd(REG_COUNT, 0);
    // async reset with a flag and interrupt pending
    mtc0(REG_COMPARE, 0, 52);
    mtc0(REG_COUNT, 0, 50);
    tick(10);
    push("flag0_set", 1); pop({30'b0, timer_int});
    mtc0(REG_STATUS, 0, 32'h0000_0401);
    push("int_pre_rst", 1); pop({31'b0, int_req});
    #2 rst_n = 1'b0;
    #1;
    push("arst_status", STATUS_RST); push("arst_cause", 0); push("arst_epc", 0);
    push("arst_timer", 0); push("arst_intreq", 0); push("arst_count", 0);
    pop(status); pop(cause); pop(epc); pop({30'b0, timer_int}); pop({31'b0, int_req});
    pop_rd(REG_COUNT, 0);
    tick();
    rst_n = 1'b1;
    tick(3);
    push("post_rst_cnt0", 0); pop_rd(REG_COUNT, 0);
    tick();
    push("post_rst_cnt1", 1); pop_rd(REG_COUNT, 0);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
